// File: rtl/spi_target_responder_if.sv
// Pin-level SPI link plus the local reply/receive/status signals of the target responder.
// "master" is the side driving the SPI pins and the local controls; "slave" is the responder.
interface spi_target_responder_if #(
   parameter int DATA_W = 16
);
   logic              spi_clk;
   logic              spi_cs_l;
   logic              spi_data;
   logic              master_data;
   logic [DATA_W-1:0] tx_word;
   logic              tx_load;
   logic [DATA_W-1:0] rx_word;
   logic              rx_valid;
   logic              busy;
   logic [7:0]        frame_cnt;
   logic              err_short;
   logic              err_over;
   logic              err_clr;

   modport master (
      output spi_clk, spi_cs_l, spi_data, tx_word, tx_load, err_clr,
      input  master_data, rx_word, rx_valid, busy, frame_cnt, err_short, err_over
   );

   modport slave (
      input  spi_clk, spi_cs_l, spi_data, tx_word, tx_load, err_clr,
      output master_data, rx_word, rx_valid, busy, frame_cnt, err_short, err_over
   );
endinterface

// File: rtl/spi_target_responder.sv
// Mode-0 SPI target: oversamples SCLK/CS/MOSI on PCLK, assembles DATA_W-bit MSB-first frames
// and shifts a reply word out on MISO. Reply defaults to an echo of the previous frame.
module spi_target_responder #(
   parameter int DATA_W = 16,
   parameter bit ECHO   = 1'b1
) (
   input logic                     PCLK,
   input logic                     PRESETn,
   spi_target_responder_if.slave   bus
);
   localparam int CNT_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {
      WAIT_IDLE = 2'd0,
      IDLE      = 2'd1,
      SHIFT     = 2'd2,
      DONE      = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic [1:0] sclk_sync_q;
   logic [1:0] cs_sync_q;
   logic [1:0] mosi_sync_q;
   logic       sclk_hist_q;
   logic       cs_hist_q;

   logic sclk_s, cs_s, mosi_s;
   logic sclk_rise, sclk_fall, cs_rise, cs_fall;

   logic [DATA_W-1:0] shift_out_q, shift_out_d;
   logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
   logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
   logic [DATA_W-1:0] rx_word_q, rx_word_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]        frame_cnt_q, frame_cnt_d;
   logic              valid_pend_q;
   logic              rx_valid_q;
   logic              busy_q, busy_d;
   logic              master_data_q, master_data_d;
   logic              err_short_q, err_short_d;
   logic              err_over_q, err_over_d;

   logic [DATA_W-1:0] assembled;
   logic              last_bit;
   logic              start_frame, rx_bit, tx_bit, complete, short_evt, over_evt;

   // Synchronizers reset low so a reset released with CS held low is seen as "not idle".
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '0;
         mosi_sync_q <= '0;
         sclk_hist_q <= 1'b0;
         cs_hist_q   <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[0], bus.spi_clk};
         cs_sync_q   <= {cs_sync_q[0], bus.spi_cs_l};
         mosi_sync_q <= {mosi_sync_q[0], bus.spi_data};
         sclk_hist_q <= sclk_sync_q[1];
         cs_hist_q   <= cs_sync_q[1];
      end
   end

   assign sclk_s    = sclk_sync_q[1];
   assign cs_s      = cs_sync_q[1];
   assign mosi_s    = mosi_sync_q[1];
   assign sclk_rise = sclk_s & ~sclk_hist_q;
   assign sclk_fall = ~sclk_s & sclk_hist_q;
   assign cs_rise   = cs_s & ~cs_hist_q;
   assign cs_fall   = ~cs_s & cs_hist_q;

   assign last_bit  = (bit_cnt_q == CNT_W'(DATA_W - 1));
   assign assembled = {rx_shift_q[DATA_W-2:0], mosi_s};

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state_q <= WAIT_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         WAIT_IDLE: if (cs_s) state_d = IDLE;
         IDLE:      if (cs_fall) state_d = SHIFT;
         SHIFT: begin
            if (cs_rise) begin
               state_d = IDLE;
            end else if (sclk_rise && last_bit) begin
               state_d = DONE;
            end
         end
         DONE:      if (cs_rise) state_d = IDLE;
         default:   state_d = WAIT_IDLE;
      endcase
   end

   // CS rising edge outranks any SCLK edge detected in the same cycle.
   always_comb begin
      start_frame = 1'b0;
      rx_bit      = 1'b0;
      tx_bit      = 1'b0;
      complete    = 1'b0;
      short_evt   = 1'b0;
      over_evt    = 1'b0;
      unique case (state_q)
         IDLE: start_frame = cs_fall;
         SHIFT: begin
            if (cs_rise) begin
               short_evt = 1'b1;
            end else begin
               rx_bit   = sclk_rise;
               tx_bit   = sclk_fall;
               complete = sclk_rise & last_bit;
            end
         end
         DONE: over_evt = sclk_rise & ~cs_rise;
         default: ;
      endcase
   end

   always_comb begin
      shift_out_d = shift_out_q;
      rx_shift_d  = rx_shift_q;
      bit_cnt_d   = bit_cnt_q;
      tx_buf_d    = tx_buf_q;
      rx_word_d   = rx_word_q;
      frame_cnt_d = frame_cnt_q;

      if (start_frame) begin
         shift_out_d = bus.tx_load ? bus.tx_word : tx_buf_q;
         bit_cnt_d   = '0;
      end else if (tx_bit) begin
         shift_out_d = {shift_out_q[DATA_W-2:0], 1'b0};
      end

      if (rx_bit) begin
         rx_shift_d = assembled;
         bit_cnt_d  = bit_cnt_q + 1'b1;
      end

      if (complete) begin
         rx_word_d   = assembled;
         frame_cnt_d = frame_cnt_q + 8'd1;
      end

      // An explicit load always beats the echo of the word just received.
      if (bus.tx_load) begin
         tx_buf_d = bus.tx_word;
      end else if (complete && ECHO) begin
         tx_buf_d = assembled;
      end
   end

   always_comb begin
      busy_d        = (state_d == SHIFT) || (state_d == DONE);
      master_data_d = ((state_q == SHIFT) || (state_q == DONE)) ? shift_out_q[DATA_W-1] : 1'b0;
      err_short_d   = short_evt | (err_short_q & ~bus.err_clr);
      err_over_d    = over_evt  | (err_over_q  & ~bus.err_clr);
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         shift_out_q   <= '0;
         rx_shift_q    <= '0;
         bit_cnt_q     <= '0;
         tx_buf_q      <= '0;
         rx_word_q     <= '0;
         frame_cnt_q   <= '0;
         valid_pend_q  <= 1'b0;
         rx_valid_q    <= 1'b0;
         busy_q        <= 1'b0;
         master_data_q <= 1'b0;
         err_short_q   <= 1'b0;
         err_over_q    <= 1'b0;
      end else begin
         shift_out_q   <= shift_out_d;
         rx_shift_q    <= rx_shift_d;
         bit_cnt_q     <= bit_cnt_d;
         tx_buf_q      <= tx_buf_d;
         rx_word_q     <= rx_word_d;
         frame_cnt_q   <= frame_cnt_d;
         valid_pend_q  <= complete;
         rx_valid_q    <= valid_pend_q;
         busy_q        <= busy_d;
         master_data_q <= master_data_d;
         err_short_q   <= err_short_d;
         err_over_q    <= err_over_d;
      end
   end

   assign bus.master_data = master_data_q;
   assign bus.rx_word     = rx_word_q;
   assign bus.rx_valid    = rx_valid_q;
   assign bus.busy        = busy_q;
   assign bus.frame_cnt   = frame_cnt_q;
   assign bus.err_short   = err_short_q;
   assign bus.err_over    = err_over_q;
endmodule
